// File: rtl/mov_ctrl.sv
// Row-buffer to temp-register move sequencer: reads CNT words and loads them one at a time
// into temp register DST, yielding to PIM compute. Optional command checking: MOV_CTRL_ERR_EN.
module mov_ctrl #(
  parameter int N    = 10,
  parameter int NREG = 4,
  parameter int AW   = 6,
  parameter int CW   = 6,
  localparam int DW  = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [AW-1:0]   cmd_src,
  input  logic [DW-1:0]   cmd_dst,
  input  logic [CW-1:0]   cmd_len,
  input  logic            pim_busy,
  output logic            rd_en,
  output logic [AW-1:0]   rd_addr,
  input  logic [N-1:0]    rd_data,
  output logic [N-1:0]    MOV_in,
  output logic [NREG-1:0] Mov_load,
  output logic            done,
  output logic            err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_LOAD,
    S_DONE,
    S_ERR
  } state_t;

  state_t          state_reg;
  logic [AW-1:0]   addr_reg;
  logic [DW-1:0]   dst_reg;
  logic [CW-1:0]   rem_reg;
  logic [N-1:0]    mov_in_reg;
  logic            cmd_ready_reg;
  logic            done_reg;
  logic            err_reg;
  logic            cmd_bad;
  logic            load_fire;

`ifdef MOV_CTRL_ERR_EN
  localparam int SW    = ((AW > CW) ? AW : CW) + 1;
  localparam int DEPTH = 2 ** AW;

  logic [NREG-1:0] cmd_dst_hit;
  logic [SW-1:0]   cmd_end;

  for (genvar gi = 0; gi < NREG; gi++) begin : g_dst_hit
    assign cmd_dst_hit[gi] = (cmd_dst == DW'(gi));
  end

  // One past the last word touched; equal to DEPTH is still in range.
  assign cmd_end = SW'(cmd_src) + SW'(cmd_len);
  assign cmd_bad = (cmd_end > SW'(DEPTH)) || (cmd_dst_hit == '0);
`else
  assign cmd_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      addr_reg      <= '0;
      dst_reg       <= '0;
      rem_reg       <= '0;
      mov_in_reg    <= '0;
      cmd_ready_reg <= 1'b1;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (cmd_valid) begin
            addr_reg      <= cmd_src;
            dst_reg       <= cmd_dst;
            rem_reg       <= cmd_len;
            cmd_ready_reg <= 1'b0;
            if (cmd_bad) begin
              state_reg <= S_ERR;
              err_reg   <= 1'b1;
            end else if (cmd_len == '0) begin
              state_reg <= S_DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= S_READ;
            end
          end
        end
        S_READ: begin
          if (!pim_busy) state_reg <= S_WAIT;
        end
        S_WAIT: begin
          mov_in_reg <= rd_data;
          state_reg  <= S_LOAD;
        end
        S_LOAD: begin
          // A stalled load keeps mov_in_reg untouched, so no word is lost.
          if (!pim_busy) begin
            addr_reg <= addr_reg + AW'(1);
            rem_reg  <= rem_reg - CW'(1);
            if (rem_reg == CW'(1)) begin
              state_reg <= S_DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= S_READ;
            end
          end
        end
        S_DONE, S_ERR: begin
          state_reg     <= S_IDLE;
          cmd_ready_reg <= 1'b1;
        end
        default: begin
          state_reg     <= S_IDLE;
          cmd_ready_reg <= 1'b1;
        end
      endcase
    end
  end

  // Strobes see pim_busy in the same cycle so a Mov_load never collides with PIM_load.
  assign load_fire = (state_reg == S_LOAD) && !pim_busy;
  assign rd_en     = (state_reg == S_READ) && !pim_busy;
  assign rd_addr   = addr_reg;
  assign MOV_in    = mov_in_reg;
  assign cmd_ready = cmd_ready_reg;
  assign done      = done_reg;
  assign err       = err_reg;

  // An index with no matching register simply decodes to no strobe.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_load
    assign Mov_load[gi] = load_fire && (dst_reg == DW'(gi));
  end

endmodule

// File: tb/tb_mov_ctrl.sv
// Self-checking bench for mov_ctrl: directed vector table, reset corner cases and
// randomized commands checked against a transaction-level scoreboard.
module tb_mov_ctrl;
  localparam int N     = 10;
  localparam int NREG  = 4;
  localparam int AW    = 6;
  localparam int CW    = 6;
  localparam int DEPTH = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [AW-1:0]   cmd_src;
  logic [1:0]      cmd_dst;
  logic [CW-1:0]   cmd_len;
  logic            pim_busy;
  logic            rd_en;
  logic [AW-1:0]   rd_addr;
  logic [N-1:0]    rd_data;
  logic [N-1:0]    MOV_in;
  logic [NREG-1:0] Mov_load;
  logic            done;
  logic            err;

  mov_ctrl #(.N(N), .NREG(NREG), .AW(AW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len), .pim_busy(pim_busy),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .MOV_in(MOV_in),
    .Mov_load(Mov_load), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [N-1:0] mem [DEPTH];

  // Values sampled on the falling edge of the current cycle.
  logic            s_rd_en, s_done, s_err, s_ready, s_busy;
  logic [AW-1:0]   s_rd_addr;
  logic [N-1:0]    s_mov_in;
  logic [NREG-1:0] s_ml;

  // Per-command event log, indexed by cycle relative to acceptance.
  int rel;
  int rd_rel[$];
  int rd_adr[$];
  int ld_rel[$];
  int ld_dat[$];
  int ld_vec[$];
  int done_rel;
  int err_rel;
  logic [N-1:0] mov_trace [256];

  typedef struct {
    int src; int dst; int len; int bf; int bl;
    int e_rd; int e_ld; int e_done; int e_err;
  } vec_t;
  vec_t vt [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
    end
  endtask

  task automatic clear_log();
    rd_rel.delete(); rd_adr.delete(); ld_rel.delete(); ld_dat.delete(); ld_vec.delete();
    done_rel = -1;
    err_rel  = -1;
    rel      = 0;
  endtask

  // Evaluate one cycle: sample at negedge, log, then advance and answer the read.
  task automatic step();
    logic legal;
    @(negedge clk);
    s_rd_en = rd_en; s_rd_addr = rd_addr; s_done = done; s_err = err;
    s_ready = cmd_ready; s_mov_in = MOV_in; s_ml = Mov_load; s_busy = pim_busy;
    if (s_rd_en) begin rd_rel.push_back(rel); rd_adr.push_back(int'(s_rd_addr)); end
    if (s_ml != '0) begin
      ld_rel.push_back(rel); ld_dat.push_back(int'(s_mov_in)); ld_vec.push_back(int'(s_ml));
    end
    if (s_done && done_rel < 0) done_rel = rel;
    if (s_err && err_rel < 0) err_rel = rel;
    if (rel < 256) mov_trace[rel] = s_mov_in;
    legal = ((s_ml & (s_ml - 1'b1)) == '0) && !((s_ml != '0) && s_busy);
    check("mov_load_legal", legal, 1);
    @(posedge clk);
    #1;
    rd_data = s_rd_en ? mem[s_rd_addr] : N'($urandom);
    rel++;
  endtask

  task automatic run_cmd(input int src, input int dst, input int len,
                         input int bf, input int bl, input bit rnd_busy);
    int w;
    cmd_valid = 1'b0;
    pim_busy  = 1'b0;
    w = 0;
    while (!cmd_ready && w < 50) begin step(); w++; end
    check("cmd_ready_wait", cmd_ready, 1);
    clear_log();
    cmd_valid = 1'b1;
    cmd_src   = AW'(src);
    cmd_dst   = 2'(dst);
    cmd_len   = CW'(len);
    pim_busy  = rnd_busy ? ($urandom_range(0, 2) == 0) : (0 >= bf && 0 < bf + bl);
    step();
    cmd_valid = 1'b0;
    cmd_src   = AW'($urandom);
    cmd_dst   = 2'($urandom);
    cmd_len   = CW'($urandom);
    while (done_rel < 0 && err_rel < 0 && rel < 200) begin
      pim_busy = rnd_busy ? ($urandom_range(0, 2) == 0) : (rel >= bf && rel < bf + bl);
      step();
    end
    pim_busy = 1'b0;
    check("cmd_complete", (done_rel >= 0 || err_rel >= 0), 1);
    step();
    check("pulse_one_cycle", s_done | s_err, 0);
    check("ready_after_cmd", s_ready, 1);
    $display("[TB] cmd src=%0d dst=%0d len=%0d reads=%0d loads=%0d done@%0d err@%0d",
             src, dst, len, rd_rel.size(), ld_rel.size(), done_rel, err_rel);
  endtask

  // Scoreboard: the move is the list of words src, src+1, ... (mod DEPTH) into dst.
  task automatic check_cmd(input int src, input int dst, input int len);
    bit bad;
    int a;
    bad = 1'b0;
`ifdef MOV_CTRL_ERR_EN
    bad = (src + len > DEPTH) || (dst >= NREG);
`endif
    if (bad) begin
      check("err_seen", err_rel >= 0, 1);
      check("err_no_done", done_rel, -1);
      check("err_no_reads", rd_rel.size(), 0);
      check("err_no_loads", ld_rel.size(), 0);
    end else begin
      check("done_seen", done_rel >= 0, 1);
      check("no_err", err_rel, -1);
      check("read_count", rd_rel.size(), len);
      check("load_count", ld_rel.size(), (dst < NREG) ? len : 0);
      for (int k = 0; k < rd_rel.size() && k < len; k++) begin
        a = (src + k) % DEPTH;
        check("read_addr", rd_adr[k], a);
      end
      for (int k = 0; k < ld_rel.size() && k < len && k < rd_rel.size(); k++) begin
        a = (src + k) % DEPTH;
        check("load_data", ld_dat[k], int'(mem[a]));
        check("load_vec", ld_vec[k], 1 << dst);
        check("load_after_read", ld_rel[k] >= rd_rel[k] + 2, 1);
        if (k + 1 < rd_rel.size()) check("read_after_load", rd_rel[k + 1] > ld_rel[k], 1);
      end
      if (ld_rel.size() > 0) check("done_after_load", done_rel > ld_rel[ld_rel.size() - 1], 1);
    end
  endtask

  initial begin
    int idle_rd;
    rst = 1'b1; cmd_valid = 1'b0; cmd_src = '0; cmd_dst = '0; cmd_len = '0;
    pim_busy = 1'b0; rd_data = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = N'(i + 100);
    clear_log();

    // Reset state after two reset cycles.
    step(); step();
    check("rst_cmd_ready", s_ready, 1);
    check("rst_rd_en", s_rd_en, 0);
    check("rst_rd_addr", s_rd_addr, 0);
    check("rst_mov_in", s_mov_in, 0);
    check("rst_mov_load", s_ml, 0);
    check("rst_done", s_done, 0);
    check("rst_err", s_err, 0);
    rst = 1'b0;

    // src dst len busy_from busy_len | first_rd first_ld done err
    vt[0] = '{5, 2, 3, 0, 0, 1, 3, 10, -1};
    vt[1] = '{5, 2, 3, 3, 2, 1, 5, 12, -1};
    vt[2] = '{7, 1, 0, 0, 0, -1, -1, 1, -1};
`ifdef MOV_CTRL_ERR_EN
    vt[3] = '{62, 1, 3, 0, 0, -1, -1, -1, 1};
`else
    vt[3] = '{62, 1, 3, 0, 0, 1, 3, 10, -1};
`endif
    vt[4] = '{0, 3, 1, 0, 0, 1, 3, 4, -1};
    vt[5] = '{20, 0, 2, 1, 3, 4, 6, 10, -1};
    vt[6] = '{60, 2, 4, 0, 0, 1, 3, 13, -1};

    for (int v = 0; v < 7; v++) begin
      run_cmd(vt[v].src, vt[v].dst, vt[v].len, vt[v].bf, vt[v].bl, 1'b0);
      check("vec_first_rd", (rd_rel.size() > 0) ? rd_rel[0] : -1, vt[v].e_rd);
      check("vec_first_ld", (ld_rel.size() > 0) ? ld_rel[0] : -1, vt[v].e_ld);
      check("vec_done", done_rel, vt[v].e_done);
      check("vec_err", err_rel, vt[v].e_err);
      check_cmd(vt[v].src, vt[v].dst, vt[v].len);
      if (v == 0 && ld_rel.size() == 3) check("vec0_last_ld", ld_rel[2], 9);
      if (v == 1) begin
        check("stall_mov_in_c3", mov_trace[3], 105);
        check("stall_mov_in_c4", mov_trace[4], 105);
        check("stall_mov_in_c5", mov_trace[5], 105);
      end
    end

    // Reset during the second WAIT aborts the command.
    clear_log();
    cmd_valid = 1'b1; cmd_src = 6'd5; cmd_dst = 2'd2; cmd_len = 6'd3;
    step();
    cmd_valid = 1'b0;
    for (int i = 1; i < 5; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check("abort_ready", s_ready, 1);
    check("abort_mov_load", s_ml, 0);
    check("abort_mov_in", s_mov_in, 0);
    check("abort_done", s_done, 0);
    clear_log();
    for (int i = 0; i < 10; i++) step();
    idle_rd = rd_rel.size() + ld_rel.size();
    check("abort_quiet", idle_rd, 0);
    check("abort_no_done", done_rel, -1);
    run_cmd(5, 2, 3, 0, 0, 1'b0);
    check("post_abort_done", done_rel, 10);
    check_cmd(5, 2, 3);

    // Randomized commands with random PIM contention.
    for (int t = 0; t < 40; t++) begin
      int src, dst, len;
      for (int i = 0; i < DEPTH; i++) mem[i] = N'($urandom);
      src = $urandom_range(0, DEPTH - 1);
      dst = $urandom_range(0, NREG - 1);
      len = $urandom_range(0, 8);
      run_cmd(src, dst, len, 0, 0, 1'b1);
      check_cmd(src, dst, len);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
